// File: rtl/vga_tty_text_ctrl.sv
// Text-mode VGA terminal: sync generator, circular char buffer with TTY write
// semantics, row-offset hardware scroll, blinking underline cursor, RGB output.
module vga_tty_text_ctrl #(
   parameter int unsigned H_ACTIVE     = 640,
   parameter int unsigned H_FP         = 16,
   parameter int unsigned H_SYNC       = 96,
   parameter int unsigned H_BP         = 48,
   parameter int unsigned V_ACTIVE     = 480,
   parameter int unsigned V_FP         = 10,
   parameter int unsigned V_SYNC       = 2,
   parameter int unsigned V_BP         = 33,
   parameter int unsigned COLS         = 80,
   parameter int unsigned ROWS         = 30,
   parameter int unsigned COLOR_BITS   = 1,
   parameter int unsigned BLINK_FRAMES = 32
) (
   input  logic                    clk_50mhz,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [7:0]              wr_data,
   output logic                    busy,
   output logic [6:0]              cursor_col,
   output logic [4:0]              cursor_row,
   input  logic                    cursor_en,
   input  logic [3*COLOR_BITS-1:0] fg_color,
   input  logic [3*COLOR_BITS-1:0] bg_color,
   output logic [11:0]             font_addr,
   input  logic [7:0]              font_data,
   output logic [COLOR_BITS-1:0]   vga_red,
   output logic [COLOR_BITS-1:0]   vga_green,
   output logic [COLOR_BITS-1:0]   vga_blue,
   output logic                    vga_hsync,
   output logic                    vga_vsync
);
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned CELLS   = COLS * ROWS;
   localparam int unsigned AW      = $clog2(CELLS);
   localparam int unsigned BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int unsigned CW      = 3 * COLOR_BITS;

   typedef enum logic [1:0] {StInitClear, StIdle, StScrollClear} state_e;

   // Logical row + scroll offset, wrapped into the physical RAM row.
   function automatic logic [4:0] phys_row(input logic [4:0] lrow, input logic [4:0] top);
      logic [5:0] s;
      s = {1'b0, lrow} + {1'b0, top};
      return (s >= 6'(ROWS)) ? 5'(s - 6'(ROWS)) : s[4:0];
   endfunction

   function automatic logic [AW-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
      return AW'(prow) * AW'(COLS) + AW'(col);
   endfunction

   logic          pix_q, pix_d, tick;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_q, blink_d;

   state_e        state_q, state_d;
   logic [AW-1:0] clr_q, clr_d;
   logic [6:0]    col_q, col_d;
   logic [4:0]    row_q, row_d;
   logic [4:0]    top_q, top_d;
   logic          ram_we, adv;
   logic [AW-1:0] ram_waddr, cur_addr;
   logic [7:0]    ram_wdata;

   logic          act0, hs0, vs0, cur0;
   logic [6:0]    col0;
   logic [4:0]    lrow0;
   logic [AW-1:0] raddr;

   logic [7:0]    mem [CELLS];
   logic [7:0]    rd_char_q;
   logic          s1_act_q, s1_hs_q, s1_vs_q, s1_cur_q;
   logic [3:0]    s1_line_q;
   logic [2:0]    s1_px_q;
   logic          s2_act_q, s2_hs_q, s2_vs_q, s2_cur_q;
   logic [2:0]    s2_px_q;
   logic [11:0]   font_addr_q;
   logic [CW-1:0] rgb_q, rgb_d;
   logic          hs_q, vs_q;

   // Pixel tick and h/v counters; blink phase advances on vsync starts.
   always_comb begin
      pix_d       = ~pix_q;
      tick        = pix_q;
      h_d         = h_q;
      v_d         = v_q;
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      if (tick) begin
         if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
            if (v_q == VW'(V_ACTIVE + V_FP - 1)) begin
               if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                  blink_cnt_d = '0;
                  blink_d     = ~blink_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + BW'(1);
               end
            end
         end else begin
            h_d = h_q + HW'(1);
         end
      end
   end

   // Timing state registers.
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         pix_q       <= 1'b0;
         h_q         <= '0;
         v_q         <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         pix_q       <= pix_d;
         h_q         <= h_d;
         v_q         <= v_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end

   // T0 decode: syncs, active area, cursor hit and char RAM read address.
   always_comb begin
      act0  = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
      hs0   = ~((h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
      vs0   = ~((v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
      col0  = 7'(h_q >> 3);
      lrow0 = 5'(v_q >> 4);
      // Blanking addresses are parked at 0 so the wrap logic never sees rows >= ROWS.
      raddr = act0 ? cell_addr(phys_row(lrow0, top_q), col0) : '0;
      cur0  = cursor_en && blink_q && act0 && (col0 == col_q) && (lrow0 == row_q) &&
              (v_q[3:1] == 3'b111);
   end

   // Char RAM: FSM write port every clock, video read port on pix_tick.
   always_ff @(posedge clk_50mhz) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (tick) rd_char_q <= mem[raddr];
   end

   // T2 colour select from the glyph row returned by the font ROM.
   always_comb begin
      rgb_d = '0;
      if (s2_act_q) rgb_d = (s2_cur_q || font_data[3'd7 - s2_px_q]) ? fg_color : bg_color;
   end

   // Three-stage video pipeline; syncs ride along to stay aligned with colour.
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         {s1_act_q, s1_cur_q, s1_line_q, s1_px_q} <= '0;
         {s1_hs_q, s1_vs_q}                       <= 2'b11;
         {s2_act_q, s2_cur_q, s2_px_q}            <= '0;
         {s2_hs_q, s2_vs_q}                       <= 2'b11;
         font_addr_q                              <= '0;
         rgb_q                                    <= '0;
         {hs_q, vs_q}                             <= 2'b11;
      end else if (tick) begin
         {s1_act_q, s1_hs_q, s1_vs_q, s1_cur_q} <= {act0, hs0, vs0, cur0};
         s1_line_q                              <= v_q[3:0];
         s1_px_q                                <= h_q[2:0];
         {s2_act_q, s2_hs_q, s2_vs_q, s2_cur_q} <= {s1_act_q, s1_hs_q, s1_vs_q, s1_cur_q};
         s2_px_q                                <= s1_px_q;
         font_addr_q                            <= {rd_char_q, s1_line_q};
         rgb_q                                  <= rgb_d;
         {hs_q, vs_q}                           <= {s2_hs_q, s2_vs_q};
      end
   end

   // Write FSM next state: buffer clears and TTY byte decode.
   always_comb begin
      state_d   = state_q;
      clr_d     = clr_q;
      col_d     = col_q;
      row_d     = row_q;
      top_d     = top_q;
      ram_we    = 1'b0;
      ram_waddr = clr_q;
      ram_wdata = 8'h20;
      adv       = 1'b0;
      cur_addr  = cell_addr(phys_row(row_q, top_q), col_q);
      unique case (state_q)
         StInitClear: begin
            ram_we = 1'b1;
            if (clr_q == AW'(CELLS - 1)) begin
               clr_d   = '0;
               state_d = StIdle;
            end else begin
               clr_d = clr_q + AW'(1);
            end
         end
         StScrollClear: begin
            // top_q already advanced, so logical bottom row maps to the freed row.
            ram_we    = 1'b1;
            ram_waddr = cell_addr(phys_row(5'(ROWS - 1), top_q), 7'(clr_q));
            if (clr_q == AW'(COLS - 1)) begin
               clr_d   = '0;
               state_d = StIdle;
            end else begin
               clr_d = clr_q + AW'(1);
            end
         end
         StIdle: begin
            if (wr_en) begin
               if (wr_data >= 8'h20 && wr_data <= 8'h7E) begin
                  ram_we    = 1'b1;
                  ram_waddr = cur_addr;
                  ram_wdata = wr_data;
                  if (col_q == 7'(COLS - 1)) begin
                     col_d = '0;
                     adv   = 1'b1;
                  end else begin
                     col_d = col_q + 7'd1;
                  end
               end else if (wr_data == 8'h0D) begin
                  col_d = '0;
               end else if (wr_data == 8'h0A) begin
                  col_d = '0;
                  adv   = 1'b1;
               end else if (wr_data == 8'h08 && col_q != 7'd0) begin
                  col_d     = col_q - 7'd1;
                  ram_we    = 1'b1;
                  ram_waddr = cur_addr - AW'(1);
               end
               if (adv) begin
                  if (row_q == 5'(ROWS - 1)) begin
                     top_d   = (top_q == 5'(ROWS - 1)) ? '0 : top_q + 5'd1;
                     clr_d   = '0;
                     state_d = StScrollClear;
                  end else begin
                     row_d = row_q + 5'd1;
                  end
               end
            end
         end
         default: state_d = StInitClear;
      endcase
   end

   // Write FSM and cursor registers.
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         state_q <= StInitClear;
         clr_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         top_q   <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         col_q   <= col_d;
         row_q   <= row_d;
         top_q   <= top_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign cursor_col = col_q;
   assign cursor_row = row_q;
   assign font_addr  = font_addr_q;
   assign vga_red    = rgb_q[CW-1 -: COLOR_BITS];
   assign vga_green  = rgb_q[COLOR_BITS +: COLOR_BITS];
   assign vga_blue   = rgb_q[0 +: COLOR_BITS];
   assign vga_hsync  = hs_q;
   assign vga_vsync  = vs_q;

endmodule

// File: doc/vga_tty_text_ctrl.md
Name: vga_tty_text_ctrl

Overview:
- Parametrised text-mode VGA terminal controller; successor to the fixed 1-bit-colour VGA TTY block.
- Contains:
  - generic sync/timing generator;
  - circular character buffer with TTY write semantics (CR, LF, BS, wrap);
  - hardware scroll via a row-offset register;
  - blinking underline cursor;
  - multi-bit RGB output.
- Sits between the CPU bus write decode (byte writes) and the board VGA connector. Glyph bitmaps come from an external synchronous font ROM.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
COLS, 80, text columns (H_ACTIVE/8; glyph width fixed at 8)
ROWS, 30, text rows (V_ACTIVE/16; glyph height fixed at 16)
COLOR_BITS, 1, bits per colour channel
BLINK_FRAMES, 32, frames per cursor blink half-period

Ports:
clk_50mhz  in  1  system clock; pixel rate = clk_50mhz/2 via internal pix_tick
rst  in  1  asynchronous, active-high reset
wr_en  in  1  one-cycle byte write strobe, sampled on clk_50mhz
wr_data  in  8  character/control code
busy  out  1  high while the buffer is being cleared; writes are dropped
cursor_col  out  7  current cursor column
cursor_row  out  5  current logical cursor row
cursor_en  in  1  enables the cursor overlay
fg_color  in  3*COLOR_BITS  foreground colour {R,G,B}
bg_color  in  3*COLOR_BITS  background colour {R,G,B}
font_addr  out  12  {char[7:0], glyph_line[3:0]} to the font ROM
font_data  in  8  glyph row returned one pix_tick after font_addr; bit 7 = leftmost pixel
vga_red / vga_green / vga_blue  out  COLOR_BITS each  pixel colour
vga_hsync  out  1  active-low
vga_vsync  out  1  active-low

Behaviour:
Reset values:
- All counters, cursor, top_row and blink counter = 0.
- RGB = 0; hsync = vsync = 1.
- busy = 1: FSM enters INIT_CLEAR.

Timing generator:
- pix_tick toggles every clk_50mhz.
- h_cnt advances on pix_tick, range 0..H_TOTAL-1; it wraps and increments v_cnt, range 0..V_TOTAL-1.
- hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v_cnt.

Pixel pipeline (3 pix_ticks):
- T0: char RAM read at physical row ((v_cnt>>4)+top_row) mod ROWS, column h_cnt>>3.
- T1: font_addr registered.
- T2: font_data bit [7-(h&7)] selects fg/bg; output registered.
- hsync, vsync and the active flag are delayed by the same 3 ticks, so colour and sync stay aligned.
- Outside the active area, RGB = 0.

Cursor:
- Glyph lines 14–15 of the cell at (cursor_col, cursor_row) are forced to fg.
- Applies only when cursor_en = 1 and the blink phase is on.
- Blink phase toggles every BLINK_FRAMES vsync starts.

Write FSM (clk_50mhz domain; the char RAM write port is independent of the read port):
- INIT_CLEAR: writes 0x20 to all COLS*ROWS cells, one per clk. Then goes to IDLE and busy falls, exactly COLS*ROWS clocks after reset release.
- IDLE, wr_en=1, by wr_data:
  - 0x20–0x7E: store at cursor, col+1.
  - 0x0D: col=0.
  - 0x0A: col=0, row+1.
  - 0x08: if col>0, col-1 and store 0x20 at the new col; at col 0, no-op.
  - Any other code: ignored, no state change.
- Printable at col COLS-1: stored, then col=0, row+1.
- Row advance past ROWS-1:
  - top_row=(top_row+1) mod ROWS; cursor_row stays ROWS-1.
  - Enter SCROLL_CLEAR: writes 0x20 across the new bottom physical row, COLS clocks, busy=1.
  - Returns to IDLE.
- wr_en while busy=1: dropped, with no effect.
- The write that triggers a scroll is itself accepted.
- Reset asserted mid-clear or mid-frame: aborts immediately; restarts INIT_CLEAR on release.
- cursor_row is logical (screen) row; the physical RAM row is (cursor_row+top_row) mod ROWS.

Test Plan:
- Reset release (default params):
  - busy high exactly 2400 clocks; every cell reads 0x20.
  - hsync period 1600 clocks with low pulse 192 clocks.
  - vsync period 525 lines with low pulse 2 lines.
- After busy falls, wr_en with 0x41:
  - cell(0,0)=0x41; cursor=(1,0); busy stays 0.
  - wr_en asserted during INIT_CLEAR is dropped (cell stays 0x20).
- Write 80 printable chars from (0,0): cursor=(0,1); cell(79,0) holds the last char.
- Cursor at (5,3), write 0x0D: cursor (0,3). Then 0x08: no change. Then 0x0A: cursor (0,4).
- Cursor at (10,29), write 0x0A:
  - busy high 80 clocks; top_row=1; cursor (0,29).
  - Logical row 29 all 0x20; former logical row 1 now shown at row 0.
- Timing and colour:
  - font_data=0xFF, fg=all ones, bg=0, COLOR_BITS=2: active pixels RGB=2'b11, and RGB=0 in blanking.
  - First active pixel output 3 pix_ticks after h_cnt=0, aligned with the delayed hsync.
  - cursor_en=1: cursor lines toggle every 32 frames.
